// File: rtl/gps_corr_pkg.sv
// rtl/gps_corr_pkg.sv - widths, word selects and record type for the correlator dump FIFO
// DUMP_TIMESTAMP_EN adds a 32-bit capture timestamp to each record.
package gps_corr_pkg;

    localparam int ACC_W_DEF = 32;
    localparam int TS_W      = 32;
    localparam int NUM_ACC   = 6;

    localparam logic [2:0] SEL_IE   = 3'd0;
    localparam logic [2:0] SEL_QE   = 3'd1;
    localparam logic [2:0] SEL_IP   = 3'd2;
    localparam logic [2:0] SEL_QP   = 3'd3;
    localparam logic [2:0] SEL_IL   = 3'd4;
    localparam logic [2:0] SEL_QL   = 3'd5;
    localparam logic [2:0] SEL_TS   = 3'd6;
    localparam logic [2:0] SEL_RSVD = 3'd7;

    typedef struct packed {
`ifdef DUMP_TIMESTAMP_EN
        logic [TS_W-1:0]      ts;
`endif
        logic [ACC_W_DEF-1:0] ql;
        logic [ACC_W_DEF-1:0] il;
        logic [ACC_W_DEF-1:0] qp;
        logic [ACC_W_DEF-1:0] ip;
        logic [ACC_W_DEF-1:0] qe;
        logic [ACC_W_DEF-1:0] ie;
    } corr_rec_t;

endpackage

// File: rtl/corr_dump_ram.sv
// rtl/corr_dump_ram.sv - DEPTH x record register array, one write port, one async read port
// DUMP_TIMESTAMP_EN adds a per-record timestamp column.
module corr_dump_ram
    import gps_corr_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                             mclk,
    input  logic                             wr_en_i,
    input  logic [PTR_W-1:0]                 wr_addr_i,
    input  logic [NUM_ACC-1:0][ACC_W-1:0]    wr_acc_i,
    input  logic [PTR_W-1:0]                 rd_addr_i,
    output logic [NUM_ACC-1:0][ACC_W-1:0]    rd_acc_o
`ifdef DUMP_TIMESTAMP_EN
    ,
    input  logic [TS_W-1:0]                  wr_ts_i,
    output logic [TS_W-1:0]                  rd_ts_o
`endif
);

    // Record storage is deliberately not reset; pointers and count gate its visibility.
    logic [NUM_ACC-1:0][ACC_W-1:0] acc_q [DEPTH];

    always_ff @(posedge mclk) begin
        if (wr_en_i) begin
            acc_q[wr_addr_i] <= wr_acc_i;
        end
    end

    assign rd_acc_o = acc_q[rd_addr_i];

`ifdef DUMP_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q [DEPTH];

    always_ff @(posedge mclk) begin
        if (wr_en_i) begin
            ts_q[wr_addr_i] <= wr_ts_i;
        end
    end

    assign rd_ts_o = ts_q[rd_addr_i];
`endif

endmodule

// File: rtl/corr_dump_fifo.sv
// rtl/corr_dump_fifo.sv - record FIFO capturing E/P/L I/Q correlator dumps for register readout
// DUMP_TIMESTAMP_EN stores a free-running mclk count with each record (rd_sel_i = 6).
module corr_dump_fifo
    import gps_corr_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             mclk,
    input  logic             mclr,
    input  logic             dump_i,
    input  logic [ACC_W-1:0] ie_i,
    input  logic [ACC_W-1:0] qe_i,
    input  logic [ACC_W-1:0] ip_i,
    input  logic [ACC_W-1:0] qp_i,
    input  logic [ACC_W-1:0] il_i,
    input  logic [ACC_W-1:0] ql_i,
    input  logic [2:0]       rd_sel_i,
    input  logic             pop_i,
    input  logic             ovf_clr_i,
    output logic [ACC_W-1:0] rd_data_o,
    output logic             ready_o,
    output logic             full_o,
    output logic             overflow_o,
    output logic [PTR_W:0]   count_o
);

    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]                count_q, count_d;
    logic                          ready_q, ready_d;
    logic                          full_q, full_d;
    logic                          ovf_q, ovf_d;
    logic [ACC_W-1:0]              rd_data_q, rd_data_d;
    logic                          do_push, do_pop, drop;
    logic [NUM_ACC-1:0][ACC_W-1:0] wr_acc, rd_acc;
    logic [ACC_W-1:0]              ts_word;

    assign wr_acc = {ql_i, il_i, qp_i, ip_i, qe_i, ie_i};

`ifdef DUMP_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_q, ts_cnt_d;
    logic [TS_W-1:0] rd_ts;

    assign ts_cnt_d = ts_cnt_q + TS_W'(1);
    assign ts_word  = ACC_W'(rd_ts);

    always_ff @(posedge mclk or negedge mclr) begin
        if (!mclr) begin
            ts_cnt_q <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_d;
        end
    end
`else
    assign ts_word = '0;
`endif

    corr_dump_ram #(
        .ACC_W (ACC_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .mclk      (mclk),
        .wr_en_i   (do_push),
        .wr_addr_i (wr_ptr_q),
        .wr_acc_i  (wr_acc),
        .rd_addr_i (rd_ptr_q),
        .rd_acc_o  (rd_acc)
`ifdef DUMP_TIMESTAMP_EN
        ,
        .wr_ts_i   (ts_cnt_q),
        .rd_ts_o   (rd_ts)
`endif
    );

    // A pop on a full FIFO frees the slot the same-cycle dump lands in, so no drop.
    always_comb begin
        do_pop  = pop_i && ready_q;
        do_push = dump_i && (!full_q || do_pop);
        drop    = dump_i && full_q && !pop_i;

        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase

        ready_d = (count_d != '0);
        full_d  = (count_d == DEPTH_CNT);

        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        rd_data_d = '0;
        if (ready_q) begin
            case (rd_sel_i)
                SEL_IE:  rd_data_d = rd_acc[0];
                SEL_QE:  rd_data_d = rd_acc[1];
                SEL_IP:  rd_data_d = rd_acc[2];
                SEL_QP:  rd_data_d = rd_acc[3];
                SEL_IL:  rd_data_d = rd_acc[4];
                SEL_QL:  rd_data_d = rd_acc[5];
                SEL_TS:  rd_data_d = ts_word;
                default: rd_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge mclk or negedge mclr) begin
        if (!mclr) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ready_q   <= 1'b0;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ready_q   <= ready_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign ready_o    = ready_q;
    assign full_o     = full_q;
    assign overflow_o = ovf_q;
    assign count_o    = count_q;

endmodule

// File: tb/tb_corr_dump_fifo.sv
// tb/tb_corr_dump_fifo.sv - self-checking bench for corr_dump_fifo (table, directed and random)
// Honours DUMP_TIMESTAMP_EN to match the build under test.
module tb_corr_dump_fifo;
    import gps_corr_pkg::*;

    localparam int ACC_W = 32;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             mclk, mclr, dump_i, pop_i, ovf_clr_i;
    logic [ACC_W-1:0] ie_i, qe_i, ip_i, qp_i, il_i, ql_i;
    logic [2:0]       rd_sel_i;
    logic [ACC_W-1:0] rd_data_o;
    logic             ready_o, full_o, overflow_o;
    logic [PTR_W:0]   count_o;

    corr_dump_fifo #(.ACC_W(ACC_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .mclk(mclk), .mclr(mclr), .dump_i(dump_i),
        .ie_i(ie_i), .qe_i(qe_i), .ip_i(ip_i), .qp_i(qp_i), .il_i(il_i), .ql_i(ql_i),
        .rd_sel_i(rd_sel_i), .pop_i(pop_i), .ovf_clr_i(ovf_clr_i),
        .rd_data_o(rd_data_o), .ready_o(ready_o), .full_o(full_o),
        .overflow_o(overflow_o), .count_o(count_o)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: a queue of whole records plus a sticky flag.
    corr_rec_t   mq[$];
    bit          m_ovf;
    logic [31:0] m_rd;
    int unsigned m_cyc;

    typedef struct {
        bit          dump, pop, clr;
        bit [2:0]    sel;
        logic [31:0] ie, qe, ip, qp, il, ql;
        int          ecount;
        bit          eready, efull, eovf;
        logic [31:0] erd;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic corr_rec_t mkrec(input logic [31:0] ie, qe, ip, qp, il, ql);
        corr_rec_t r;
        r = '0;
        r.ie = ie; r.qe = qe; r.ip = ip; r.qp = qp; r.il = il; r.ql = ql;
        return r;
    endfunction

    function automatic logic [31:0] word_of(input corr_rec_t r, input bit [2:0] sel);
        case (sel)
            3'd0: return r.ie;
            3'd1: return r.qe;
            3'd2: return r.ip;
            3'd3: return r.qp;
            3'd4: return r.il;
            3'd5: return r.ql;
`ifdef DUMP_TIMESTAMP_EN
            3'd6: return r.ts;
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic drive_edge(input bit dump, input corr_rec_t r, input bit [2:0] sel,
                              input bit pop, input bit clr);
        bit popped, drop;
        dump_i = dump; pop_i = pop; ovf_clr_i = clr; rd_sel_i = sel;
        ie_i = r.ie; qe_i = r.qe; ip_i = r.ip; qp_i = r.qp; il_i = r.il; ql_i = r.ql;
        @(posedge mclk);
        m_rd   = (mq.size() == 0 || sel == 3'd7) ? 32'h0 : word_of(mq[0], sel);
        popped = pop && mq.size() != 0;
        drop   = dump && mq.size() == DEPTH && !pop;
        if (popped) void'(mq.pop_front());
        if (dump && !drop) begin
`ifdef DUMP_TIMESTAMP_EN
            r.ts = m_cyc;
`endif
            mq.push_back(r);
        end
        m_ovf = drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_cyc++;
        @(negedge mclk);
        dump_i = 1'b0; pop_i = 1'b0; ovf_clr_i = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, " count"}, 32'(count_o), 32'(mq.size()));
        check({tag, " ready"}, 32'(ready_o), 32'(mq.size() != 0));
        check({tag, " full"},  32'(full_o),  32'(mq.size() == DEPTH));
        check({tag, " ovf"},   32'(overflow_o), 32'(m_ovf));
        check({tag, " rd"},    rd_data_o, m_rd);
    endtask

    task automatic do_reset();
        mclr = 1'b0;
        dump_i = 0; pop_i = 0; ovf_clr_i = 0; rd_sel_i = 0;
        ie_i = 0; qe_i = 0; ip_i = 0; qp_i = 0; il_i = 0; ql_i = 0;
        repeat (2) @(negedge mclk);
        mclr = 1'b1;
        mq.delete();
        m_ovf = 0; m_rd = 0; m_cyc = 0;
    endtask

    task automatic add(input bit dump, pop, clr, input bit [2:0] sel,
                       input logic [31:0] ie, ip, input int ecount,
                       input bit eready, efull, eovf, input logic [31:0] erd);
        vec_t v;
        v.dump = dump; v.pop = pop; v.clr = clr; v.sel = sel;
        v.ie = ie; v.qe = ie + 1; v.ip = ip; v.qp = ie + 3; v.il = ie + 4; v.ql = ie + 5;
        v.ecount = ecount; v.eready = eready; v.efull = efull; v.eovf = eovf; v.erd = erd;
        tbl.push_back(v);
    endtask

    corr_rec_t zr;
    logic [31:0] t0, t1;

    initial begin
        zr = '0;
        // Single dump: IE..QL = 1..6, then read every word.
        add(1, 0, 0, 0, 1, 3, 1, 1, 0, 0, 0);
        for (int s = 0; s < 6; s++) add(0, 0, 0, 3'(s), 0, 0, 1, 1, 0, 0, 32'(s + 1));
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Fill and overflow: IP = k*0x100, fifth dump dropped.
        for (int k = 1; k <= 5; k++)
            add(1, 0, 0, 2, 32'(k), 32'(k * 256), (k > 4) ? 4 : k, 1, k >= 4, k == 5,
                (k == 1) ? 32'h0 : 32'h100);
        for (int j = 1; j <= 4; j++)
            add(0, 1, 0, 2, 0, 0, 4 - j, (4 - j) > 0, 0, 1, 32'(j * 256));
        add(0, 1, 0, 2, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0);

        do_reset();
        mclr = 1'b0;
        #1;
        check("reset count", 32'(count_o), 0);
        check("reset ready", 32'(ready_o), 0);
        check("reset ovf",   32'(overflow_o), 0);
        check("reset rd",    rd_data_o, 0);
        @(negedge mclk);
        mclr = 1'b1;

        foreach (tbl[i]) begin
            drive_edge(tbl[i].dump, mkrec(tbl[i].ie, tbl[i].qe, tbl[i].ip, tbl[i].qp,
                       tbl[i].il, tbl[i].ql), tbl[i].sel, tbl[i].pop, tbl[i].clr);
            check($sformatf("tbl%0d count", i), 32'(count_o), 32'(tbl[i].ecount));
            check($sformatf("tbl%0d ready", i), 32'(ready_o), 32'(tbl[i].eready));
            check($sformatf("tbl%0d full", i),  32'(full_o), 32'(tbl[i].efull));
            check($sformatf("tbl%0d ovf", i),   32'(overflow_o), 32'(tbl[i].eovf));
            check($sformatf("tbl%0d rd", i),    rd_data_o, tbl[i].erd);
        end

        // Asynchronous reset mid-stream after three pushes.
        for (int k = 0; k < 3; k++) begin
            drive_edge(1, mkrec(32'h11 + k, 2, 3, 4, 5, 6), 0, 0, 0);
            check_model("pre-rst");
        end
        #2 mclr = 1'b0;
        #1;
        check("async rst count", 32'(count_o), 0);
        check("async rst ready", 32'(ready_o), 0);
        check("async rst ovf",   32'(overflow_o), 0);
        check("async rst rd",    rd_data_o, 0);
        do_reset();

        // Full FIFO with simultaneous dump and pop, then overflow set/clear priority.
        for (int k = 0; k < 4; k++) begin
            drive_edge(1, mkrec(k, 0, 32'hA0 + k, 0, 0, 0), 2, 0, 0);
            check_model("fill");
        end
        drive_edge(1, mkrec(9, 0, 32'hE0, 0, 0, 0), 2, 1, 0);
        check("full dump+pop ovf", 32'(overflow_o), 0);
        check("full dump+pop count", 32'(count_o), 4);
        check("full dump+pop rd", rd_data_o, 32'hA0);
        drive_edge(1, mkrec(9, 0, 32'hF0, 0, 0, 0), 2, 0, 0);
        check("drop ovf", 32'(overflow_o), 1);
        drive_edge(0, zr, 2, 0, 1);
        check("clr ovf", 32'(overflow_o), 0);
        drive_edge(1, mkrec(9, 0, 32'hF1, 0, 0, 0), 2, 0, 1);
        check("clr+drop ovf", 32'(overflow_o), 1);
        check_model("clr+drop");
        for (int k = 0; k < 4; k++) begin
            drive_edge(0, zr, 2, 1, 0);
            check($sformatf("order pop%0d", k), rd_data_o, (k < 3) ? 32'hA1 + k : 32'hE0);
        end
        drive_edge(0, zr, 2, 0, 1);
        check_model("drained");

        // Pointer wrap over ten push/pop pairs.
        for (int k = 0; k < 10; k++) begin
            drive_edge(1, mkrec(0, 0, 32'hFFFF_FFF0 + k, 0, 0, 0), 2, 0, 0);
            drive_edge(0, zr, 2, 1, 0);
            check($sformatf("wrap%0d rd", k), rd_data_o, 32'hFFFF_FFF0 + k);
            check($sformatf("wrap%0d count", k), 32'(count_o), 0);
        end
        drive_edge(0, zr, 2, 1, 0);
        check_model("pop empty");
        drive_edge(1, mkrec(7, 7, 7, 7, 7, 7), 2, 0, 0);
        drive_edge(0, zr, 7, 0, 0);
        check("rsvd sel rd", rd_data_o, 0);
        drive_edge(0, zr, 6, 0, 0);
`ifdef DUMP_TIMESTAMP_EN
        check_model("ts sel");
        do_reset();
        drive_edge(1, mkrec(1, 1, 1, 1, 1, 1), 6, 0, 0);
        repeat (99) drive_edge(0, zr, 6, 0, 0);
        drive_edge(1, mkrec(2, 2, 2, 2, 2, 2), 6, 0, 0);
        t0 = rd_data_o;
        check_model("ts first");
        drive_edge(0, zr, 6, 1, 0);
        drive_edge(0, zr, 6, 0, 0);
        t1 = rd_data_o;
        check_model("ts second");
        check("ts delta", t1 - t0, 100);
`else
        check("ts sel off", rd_data_o, 0);
        t0 = 0; t1 = 0;
`endif
        drive_edge(0, zr, 0, 1, 0);
        check_model("post ts");

        // Randomised traffic against the queue model.
        for (int n = 0; n < 400; n++) begin
            drive_edge($urandom_range(0, 99) < 50,
                       mkrec($urandom, $urandom, $urandom, $urandom, $urandom, $urandom),
                       3'($urandom_range(0, 7)), $urandom_range(0, 99) < 40,
                       $urandom_range(0, 99) < 10);
            check_model($sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
